// File: rtl/gfx256_zbuffer.sv
// gfx256_zbuffer
// ---------------
// Depth-test stage that sits directly after fragment interpolation. Each
// accepted fragment (x, y, z, colour) either:
//   - depth test enabled: reads the stored 16-bit depth, compares signed z
//     against it, and on a strict pass writes z back and forwards the fragment;
//     on a fail the fragment is discarded;
//   - depth test disabled: is forwarded straight away with no memory traffic.
//
// Handshakes (all request/valid outputs are registered decodes of state):
//   - Upstream:   write_i is sampled only in WAIT; ack_o pulses for one cycle
//                 (DONE) once the fragment is finished, whether it passed or not.
//   - Depth read: z_request_o is held with a stable z_addr_o until a cycle with
//                 z_ack_i=1; z_data_i is captured in that same cycle.
//   - Depth write: zw_request_o is held with stable addr/data/sel until a cycle
//                 with zw_ack_i=1.
//   - Downstream: write_o is high for the first PIXEL cycle only; the stage
//                 waits in PIXEL until ack_i=1 (sampled from the first cycle).
//   Acks arriving outside their own state are ignored.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   enable_i                depth test enable, sampled on accept
//   zbuffer_base_i          byte address of the depth buffer
//   target_size_x_i         render target width in pixels
//   write_i / ack_o         upstream fragment valid / completion pulse
//   x_i, y_i, z_i, color_i  incoming fragment
//   z_request_o, z_addr_o, z_data_i, z_ack_i               depth read port
//   zw_request_o, zw_addr_o, zw_data_o, zw_sel_o, zw_ack_i depth write port
//   write_o / ack_i         downstream fragment valid / done
//   x_o, y_o, z_o, color_o  forwarded fragment (latched on accept)
//   dbg_o                   {enable register, state} for observation

module gfx256_zbuffer #(
    parameter int point_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [31:0]            zbuffer_base_i,
    input  logic [point_width-1:0] target_size_x_i,
    input  logic                   write_i,
    output logic                   ack_o,
    input  logic [point_width-1:0] x_i,
    input  logic [point_width-1:0] y_i,
    input  logic [point_width-1:0] z_i,
    input  logic [31:0]            color_i,
    output logic                   z_request_o,
    output logic [31:0]            z_addr_o,
    input  logic [31:0]            z_data_i,
    input  logic                   z_ack_i,
    output logic                   zw_request_o,
    output logic [31:0]            zw_addr_o,
    output logic [31:0]            zw_data_o,
    output logic [3:0]             zw_sel_o,
    input  logic                   zw_ack_i,
    output logic                   write_o,
    input  logic                   ack_i,
    output logic [point_width-1:0] x_o,
    output logic [point_width-1:0] y_o,
    output logic [point_width-1:0] z_o,
    output logic [31:0]            color_o,
    output logic [3:0]             dbg_o
);

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_READ    = 3'd1,
        S_TEST    = 3'd2,
        S_WRITE_Z = 3'd3,
        S_PIXEL   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                   state;
    logic                     enable_q;
    logic [31:0]              addr_q;
    logic [15:0]              stored_z;
    logic [2*point_width-1:0] pix_index;
    logic [31:0]              accept_addr;

    // The address is formed from the same x/y values that are latched into
    // x_o/y_o on accept, then held in addr_q so it cannot move while any
    // request is outstanding.
    assign pix_index   = (2*point_width)'(y_i) * (2*point_width)'(target_size_x_i)
                       + (2*point_width)'(x_i);
    assign accept_addr = zbuffer_base_i + 32'({pix_index, 1'b0});

    assign z_addr_o  = {addr_q[31:2], 2'b00};
    assign zw_addr_o = {addr_q[31:2], 2'b00};
    assign dbg_o     = {enable_q, state};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_WAIT;
            enable_q     <= 1'b0;
            addr_q       <= '0;
            stored_z     <= '0;
            ack_o        <= 1'b0;
            write_o      <= 1'b0;
            z_request_o  <= 1'b0;
            zw_request_o <= 1'b0;
            zw_data_o    <= '0;
            zw_sel_o     <= '0;
            x_o          <= '0;
            y_o          <= '0;
            z_o          <= '0;
            color_o      <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (write_i) begin
                        x_o      <= x_i;
                        y_o      <= y_i;
                        z_o      <= z_i;
                        color_o  <= color_i;
                        enable_q <= enable_i;
                        addr_q   <= accept_addr;
                        if (enable_i) begin
                            state       <= S_READ;
                            z_request_o <= 1'b1;
                        end else begin
                            state   <= S_PIXEL;
                            write_o <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (z_ack_i) begin
                        // Two depths share one 32-bit word; address bit 1
                        // picks the upper half.
                        stored_z    <= addr_q[1] ? z_data_i[31:16] : z_data_i[15:0];
                        z_request_o <= 1'b0;
                        state       <= S_TEST;
                    end
                end
                S_TEST: begin
                    if ($signed(z_o[15:0]) > $signed(stored_z)) begin
                        state        <= S_WRITE_Z;
                        zw_request_o <= 1'b1;
                        zw_data_o    <= {z_o[15:0], z_o[15:0]};
                        zw_sel_o     <= addr_q[1] ? 4'b1100 : 4'b0011;
                    end else begin
                        // Equal or nearer-stored depth: discard the fragment.
                        state <= S_DONE;
                        ack_o <= 1'b1;
                    end
                end
                S_WRITE_Z: begin
                    if (zw_ack_i) begin
                        zw_request_o <= 1'b0;
                        state        <= S_PIXEL;
                        write_o      <= 1'b1;
                    end
                end
                S_PIXEL: begin
                    write_o <= 1'b0;
                    if (ack_i) begin
                        state <= S_DONE;
                        ack_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    ack_o <= 1'b0;
                    state <= S_WAIT;
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfx256_zbuffer.sv
module tb_gfx256_zbuffer;

    localparam logic [2:0] ST_WAIT = 3'd0;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [31:0] zbuffer_base_i;
    logic [15:0] target_size_x_i;
    logic        write_i;
    logic        ack_o;
    logic [15:0] x_i, y_i, z_i;
    logic [31:0] color_i;
    logic        z_request_o;
    logic [31:0] z_addr_o;
    logic [31:0] z_data_i;
    logic        z_ack_i;
    logic        zw_request_o;
    logic [31:0] zw_addr_o;
    logic [31:0] zw_data_o;
    logic [3:0]  zw_sel_o;
    logic        zw_ack_i;
    logic        write_o;
    logic        ack_i;
    logic [15:0] x_o, y_o, z_o;
    logic [31:0] color_o;
    logic [3:0]  dbg_o;

    int errors = 0;
    int checks = 0;

    gfx256_zbuffer #(.point_width(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .zbuffer_base_i(zbuffer_base_i), .target_size_x_i(target_size_x_i),
        .write_i(write_i), .ack_o(ack_o),
        .x_i(x_i), .y_i(y_i), .z_i(z_i), .color_i(color_i),
        .z_request_o(z_request_o), .z_addr_o(z_addr_o),
        .z_data_i(z_data_i), .z_ack_i(z_ack_i),
        .zw_request_o(zw_request_o), .zw_addr_o(zw_addr_o),
        .zw_data_o(zw_data_o), .zw_sel_o(zw_sel_o), .zw_ack_i(zw_ack_i),
        .write_o(write_o), .ack_i(ack_i),
        .x_o(x_o), .y_o(y_o), .z_o(z_o), .color_o(color_o),
        .dbg_o(dbg_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [31:0] c, input logic en);
        x_i = x; y_i = y; z_i = z; color_i = c; enable_i = en;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
    endtask

    // Enabled fragment with zero-wait memory; ack_i given in the first PIXEL cycle.
    task automatic run_z(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [31:0] zdata, input logic exp_pass,
                         input logic [31:0] exp_addr, input logic [3:0] exp_sel);
        send(x, y, z, 32'hC0DE_0000 | 32'(x), 1'b1);
        check({tag, "_zreq"}, 32'(z_request_o), 32'd1);
        check({tag, "_zaddr"}, z_addr_o, exp_addr);
        z_ack_i = 1'b1; z_data_i = zdata;
        tick();
        z_ack_i = 1'b0; z_data_i = 32'h0;
        check({tag, "_test_zreq"}, 32'(z_request_o), 32'd0);
        tick();
        if (exp_pass) begin
            check({tag, "_zwreq"}, 32'(zw_request_o), 32'd1);
            check({tag, "_zwaddr"}, zw_addr_o, exp_addr);
            check({tag, "_zwsel"}, 32'(zw_sel_o), 32'(exp_sel));
            check({tag, "_zwdata"}, zw_data_o, {z, z});
            zw_ack_i = 1'b1;
            tick();
            zw_ack_i = 1'b0;
            check({tag, "_write_o"}, 32'(write_o), 32'd1);
            check({tag, "_zwreq_drop"}, 32'(zw_request_o), 32'd0);
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            check({tag, "_ack_o"}, 32'(ack_o), 32'd1);
        end else begin
            check({tag, "_fail_ack_o"}, 32'(ack_o), 32'd1);
            check({tag, "_fail_zwreq"}, 32'(zw_request_o), 32'd0);
            check({tag, "_fail_write_o"}, 32'(write_o), 32'd0);
        end
        tick();
        check({tag, "_ack_end"}, 32'(ack_o), 32'd0);
        check({tag, "_state_end"}, 32'(dbg_o[2:0]), 32'(ST_WAIT));
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; zbuffer_base_i = 32'h0; target_size_x_i = 16'd640;
        write_i = 1'b0; x_i = '0; y_i = '0; z_i = '0; color_i = '0;
        z_data_i = '0; z_ack_i = 1'b0; zw_ack_i = 1'b0; ack_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(dbg_o), 32'd0);
        check("rst_ack_o", 32'(ack_o), 32'd0);
        check("rst_write_o", 32'(write_o), 32'd0);
        check("rst_zreq", 32'(z_request_o), 32'd0);
        check("rst_zwreq", 32'(zw_request_o), 32'd0);
        check("rst_zaddr", z_addr_o, 32'd0);
        check("rst_zwdata", zw_data_o, 32'd0);
        check("rst_color", color_o, 32'd0);
        rst_i = 1'b0;
        tick();

        // Disabled: straight pass-through, ack_i one cycle after write_o
        send(16'd3, 16'd2, 16'd0, 32'h00AA_BBCC, 1'b0);
        check("dis_write_o", 32'(write_o), 32'd1);
        check("dis_x", 32'(x_o), 32'd3);
        check("dis_y", 32'(y_o), 32'd2);
        check("dis_color", color_o, 32'h00AA_BBCC);
        check("dis_zreq", 32'(z_request_o), 32'd0);
        tick();
        check("dis_write_once", 32'(write_o), 32'd0);
        check("dis_zwreq", 32'(zw_request_o), 32'd0);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("dis_ack_o", 32'(ack_o), 32'd1);
        tick();
        check("dis_ack_end", 32'(ack_o), 32'd0);

        // Upper half pass: 0x1000 + (1*640+5)*2 = 0x150A -> word 0x1508
        zbuffer_base_i = 32'h1000;
        run_z("pass_up", 16'd5, 16'd1, 16'h0020, 32'h0010_7777, 1'b1, 32'h1508, 4'b1100);
        // Equal depth fails
        run_z("eq_fail", 16'd5, 16'd1, 16'h0010, 32'h0010_0000, 1'b0, 32'h1508, 4'b1100);
        // Signed: 5 > -16 passes (lower half holds 5 to catch a wrong-half pick)
        run_z("sgn_pass", 16'd5, 16'd1, 16'h0005, 32'hFFF0_0005, 1'b1, 32'h1508, 4'b1100);
        // Signed: -16 > 5 fails
        run_z("sgn_fail", 16'd5, 16'd1, 16'hFFF0, 32'h0005_8000, 1'b0, 32'h1508, 4'b1100);
        // Lower half: base 0, x=4, y=0 -> byte addr 8
        zbuffer_base_i = 32'h0;
        run_z("low_half", 16'd4, 16'd0, 16'h0004, 32'h7FFF_0003, 1'b1, 32'h0008, 4'b0011);

        // Stall on read, then reset during WRITE_Z
        zbuffer_base_i = 32'h1000;
        send(16'd5, 16'd1, 16'h0020, 32'h1234_5678, 1'b1);
        check("stall_zreq_0", 32'(z_request_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_zreq", 32'(z_request_o), 32'd1);
            check("stall_zaddr", z_addr_o, 32'h1508);
        end
        z_ack_i = 1'b1; z_data_i = 32'h0010_7777;
        tick();
        z_ack_i = 1'b0;
        tick();
        check("abort_zwreq_pre", 32'(zw_request_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("abort_zwreq", 32'(zw_request_o), 32'd0);
        check("abort_zwaddr", zw_addr_o, 32'd0);
        check("abort_x", 32'(x_o), 32'd0);
        check("abort_state", 32'(dbg_o[2:0]), 32'(ST_WAIT));
        tick();
        rst_i = 1'b0;
        check("abort_no_ack", 32'(ack_o), 32'd0);
        tick();
        check("abort_no_ack2", 32'(ack_o), 32'd0);
        zbuffer_base_i = 32'h0;
        run_z("after_abort", 16'd4, 16'd0, 16'h0004, 32'h7FFF_0003, 1'b1, 32'h0008, 4'b0011);

        // Busy: write_i held high, one fragment per WAIT visit
        x_i = 16'd7; y_i = 16'd0; z_i = 16'd0; color_i = 32'h1; enable_i = 1'b0;
        write_i = 1'b1;
        tick();
        check("busy_write_1", 32'(write_o), 32'd1);
        check("busy_x_1", 32'(x_o), 32'd7);
        x_i = 16'd9;
        ack_i = 1'b1;
        tick();
        check("busy_ack_1", 32'(ack_o), 32'd1);
        check("busy_x_hold", 32'(x_o), 32'd7);
        tick();
        check("busy_wait_state", 32'(dbg_o[2:0]), 32'(ST_WAIT));
        check("busy_x_hold2", 32'(x_o), 32'd7);
        tick();
        check("busy_write_2", 32'(write_o), 32'd1);
        check("busy_x_2", 32'(x_o), 32'd9);
        tick();
        check("busy_ack_2", 32'(ack_o), 32'd1);
        write_i = 1'b0; ack_i = 1'b0;
        tick();
        tick();
        check("busy_idle", 32'(dbg_o[2:0]), 32'(ST_WAIT));
        check("busy_idle_write", 32'(write_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gfx256_zbuffer.md
# gfx256_zbuffer

Depth-test stage directly downstream of the interpolation (colour/UV/Z) stage. Accepts one interpolated fragment (x, y, z, colour) per handshake, reads the stored 16-bit depth from the depth buffer in memory, and compares it against the fragment depth. On pass, writes the new depth back and forwards the fragment to the next pixel stage. On fail, the fragment is discarded. With depth testing disabled, fragments pass straight through with no memory traffic.

## Interface
- point_width, 16: width of coordinates and depth.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  depth test enable; sampled in WAIT when write_i is accepted.
- zbuffer_base_i  in  32  byte address of depth buffer.
- target_size_x_i  in  point_width  render target width in pixels.
- write_i  in  1  upstream fragment valid.
- ack_o  out  1  one-cycle completion pulse to upstream.
- x_i, y_i  in  point_width  fragment position.
- z_i  in  point_width  signed fragment depth.
- color_i  in  32  fragment colour.
- z_request_o  out  1  depth read request.
- z_addr_o  out  32  word-aligned read address.
- z_data_i  in  32  read data.
- z_ack_i  in  1  read done.
- zw_request_o  out  1  depth write request.
- zw_addr_o  out  32  word-aligned write address.
- zw_data_o  out  32  new depth replicated in both halves.
- zw_sel_o  out  4  byte enables.
- zw_ack_i  in  1  write done.
- write_o  out  1  fragment valid to downstream.
- ack_i  in  1  downstream done.
- x_o, y_o  out  point_width  forwarded position.
- z_o  out  point_width  forwarded depth.
- color_o  out  32  forwarded colour.

## Operation
- States:
  - WAIT: idle.
  - READ: memory read in progress.
  - TEST: depth compare.
  - WRITE_Z: memory write in progress.
  - PIXEL: fragment forwarded downstream.
  - DONE: completion pulse.
- WAIT: when write_i=1, latch x_i, y_i, z_i, color_i, and enable_i into x_o, y_o, z_o, color_o and an internal enable register. Next state is READ if enable_i=1, else PIXEL. write_i is ignored in every other state.
- Address calculation:
  - pixel index = y*target_size_x_i + x, computed at 2*point_width bits, unsigned.
  - byte address = zbuffer_base_i + (index << 1), modulo 2^32.
  - Address is computed from the latched x/y, so it is stable for the whole operation.
  - z_addr_o = zw_addr_o = {byte_addr[31:2], 2'b00}.
  - byte_addr[1] selects the depth half: 1 selects [31:16], 0 selects [15:0].
- READ: z_request_o=1 until a cycle with z_ack_i=1. In that cycle, capture the selected half of z_data_i as stored depth, then go to TEST.
- TEST: one cycle. Compare signed z_o against signed stored depth.
  - Pass (z_o > stored, strict) → WRITE_Z.
  - Fail (equal or less) → DONE; fragment discarded, write_o never asserted.
- WRITE_Z: zw_request_o=1, zw_data_o={z_o,z_o}, zw_sel_o=4'b1100 if byte_addr[1]=1, else 4'b0011. Held until zw_ack_i=1, then go to PIXEL.
- PIXEL: write_o=1 in the first cycle of PIXEL only. Stay in PIXEL until ack_i=1 (ack_i is sampled in every PIXEL cycle, including the first), then go to DONE.
- DONE: ack_o=1 for exactly this cycle, then WAIT.
- z_ack_i outside READ, zw_ack_i outside WRITE_Z, and ack_i outside PIXEL are ignored.

## Timing
- Reset values:
  - state = WAIT.
  - ack_o, write_o, z_request_o, zw_request_o = 0.
  - All address, data, and select outputs = 0.
  - x_o, y_o, z_o, color_o = 0.
- Reset asserted mid-operation: all outputs clear asynchronously and requests drop immediately. No ack_o is issued for the aborted fragment.
- Request and ack outputs are registered decodes of state; no combinational path from any *_ack_i to any output.
- Minimum latency, enabled pass with zero-wait memory and ack_i in the first PIXEL cycle:
  - cycle 0: WAIT accept.
  - cycle 1: READ, z_ack_i.
  - cycle 2: TEST.
  - cycle 3: WRITE_Z, zw_ack_i.
  - cycle 4: PIXEL, write_o.
  - cycle 5: DONE, ack_o.
  - Next fragment accepted in cycle 6.
- Enabled fail: ack_o in cycle 3.
- Disabled: write_o in cycle 1, ack_o in cycle 2 at earliest.
- Stalls: z_addr_o, zw_addr_o, zw_data_o, and zw_sel_o hold stable while their request is asserted.

## Test plan
- Disabled test: enable_i=0, x=3, y=2, color=0x00AABBCC, ack_i in the cycle after write_o → no z_request_o/zw_request_o ever; write_o for 1 cycle with x_o=3, y_o=2, color_o=0x00AABBCC; ack_o 1 cycle later.
- Pass, upper half: base=0x1000, size_x=640, x=5, y=1, z_i=0x0020, z_data_i=0x0010_7777 → z_addr_o=0x1508; zw_addr_o=0x1508, zw_sel_o=4'b1100, zw_data_o=0x00200020; then write_o and ack_o.
- Fail on equal and signed compare:
  - z_i=0x0010 vs stored 0x0010 → no write request, no write_o, ack_o in cycle 3.
  - stored 0xFFF0 (-16) with z_i=0x0005 → pass.
  - stored 0x0005 with z_i=0xFFF0 → fail.
- Lower half: x=4, y=0, base=0 → byte addr 8, zw_sel_o=4'b0011, stored depth taken from z_data_i[15:0].
- Stall and abort: z_ack_i delayed 3 cycles → z_request_o held 4 cycles with constant z_addr_o. Then rst_i pulsed during WRITE_Z → zw_request_o drops at once, no ack_o; the next write_i is processed normally.
- Busy: write_i held high throughout an operation → exactly one fragment accepted per WAIT visit; a second fragment with new x/y is latched only after ack_o.
